generic_sram_line_en_arbiter: RTL and testbench
===============================================

# generic_sram_line_en_arbiter

Shares one single-port, line-enable SRAM (generic_sram_line_en_if sram_client side) between N_REQ requesters using round-robin arbitration with an optional bounded lock for multi-beat bursts. It sits between the AXI4 SRAM bridges or DMA-style clients and the physical memory macro. It also returns one-cycle-latency read data to the requester that issued the read.

## Interface
- N_REQ, 2: number of requesters, 2..8.
- MEM_ADDR_BITS, 10: SRAM word-address width.
- MEM_DATA_BITS, 1024: SRAM line width.
- MAX_HOLD, 16: maximum consecutive grants to one locked requester, ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req_read_en  in  N_REQ  per-requester read request.
- req_write_en  in  N_REQ  per-requester write request.
- req_lock  in  N_REQ  requester asks to keep the grant next cycle.
- req_addr  in  N_REQ*MEM_ADDR_BITS  address; slice i belongs to requester i.
- req_write_data  in  N_REQ*MEM_DATA_BITS  write line.
- req_gnt  out  N_REQ  one-hot access accepted this cycle.
- req_rvalid  out  N_REQ  read data valid for requester i.
- req_read_data  out  MEM_DATA_BITS  shared read-data bus; qualified by req_rvalid.
- sram_addr  out  MEM_ADDR_BITS  to SRAM.
- sram_read_en  out  1  to SRAM.
- sram_write_en  out  1  to SRAM.
- sram_write_data  out  MEM_DATA_BITS  to SRAM.
- sram_read_data  in  MEM_DATA_BITS  from SRAM, valid 1 cycle after sram_read_en.

## Operation
- Requester i is active when req_read_en[i] | req_write_en[i]. It holds addr, data, and enables stable until req_gnt[i] is sampled high. It may drop its request only after the grant.
- If read and write are both asserted, the write wins. sram_read_en stays 0 and no rvalid is generated.
- Grant is combinational from the active vector and the registered state: rr_ptr, owner, hold_cnt, locked.
- Round-robin rule: search from rr_ptr upward, with wrap, for the first active requester. After a grant to k, rr_ptr becomes (k+1) mod N_REQ.
- Lock rule: if locked=1 and requester `owner` is active, it is granted regardless of rr_ptr.
  - locked is set after any grant to k with req_lock[k]=1 and hold_cnt < MAX_HOLD-1. owner becomes k, and hold_cnt increments, or is set to 1 on a new owner.
  - locked clears when the owner goes inactive, deasserts req_lock, or reaches hold_cnt = MAX_HOLD-1. hold_cnt then returns to 0, and the next arbitration is round-robin from (owner+1).
  - The lock never starves the others for more than MAX_HOLD consecutive grants.
- SRAM mux: sram_addr and sram_write_data take the granted slice. sram_read_en and sram_write_en are the granted requester's enables after the write-priority rule. With no grant, both enables are 0 and addr/data are don't-care (driven from slice 0).
- Read return: a one-bit valid plus the granted index is registered on each read grant. The next cycle, req_rvalid[index]=1 for exactly one cycle and req_read_data = sram_read_data, passed through combinationally.
- Reads can be granted every cycle, to any requester. The return pipeline is one deep and never stalls.

## Timing
- Reset values: req_gnt=0, req_rvalid=0, sram_read_en=0, sram_write_en=0, rr_ptr=0, locked=0, hold_cnt=0. A pending rvalid is discarded by reset.
- Grant latency 0: a request in cycle t with the winning priority gets req_gnt in cycle t and the SRAM access in cycle t.
- Read data appears in cycle t+1 with req_rvalid.
- Write completes at the clk edge ending cycle t; no response is generated.
- At most one grant per cycle. Throughput is 1 access per cycle.
- Simultaneous requests: exactly one grant. Losers retry automatically because they hold their request.
- Wrap-around: rr_ptr = N_REQ-1 followed by a grant gives rr_ptr = 0.
- Reset asserted mid-read: req_rvalid goes to 0 immediately (async) and stays 0 after release until a new read grant.

## Test plan
- Single requester: requester 0 writes addr 0x005 with data A, then reads addr 0x005. Expect gnt[0] in both cycles and rvalid[0] one cycle after the read with read_data=A. req_rvalid[1] is never set.
- Contention, N_REQ=2: both requesters read continuously for 6 cycles from reset. Expect grants 0,1,0,1,0,1 and rvalid following each grant by 1 cycle to the matching index.
- Lock, MAX_HOLD=4: requester 1 asserts lock with continuous writes while requester 0 requests. Expect gnt[1] for 4 consecutive cycles, then gnt[0], then gnt[1] again.
- Read+write together: requester 0 asserts both enables on addr 0x010. Expect sram_write_en=1, sram_read_en=0, and no rvalid the next cycle.
- Reset mid-operation: read granted in cycle t and rst_n asserted low in cycle t+1. Expect req_rvalid=0, all enables 0, and rr_ptr=0 after release, so the first contended grant goes to requester 0.

Source files
------------

// File: rtl/generic_sram_line_en_arbiter.sv
// Round-robin arbiter sharing one single-port line-enable SRAM among N_REQ
// requesters. A granted requester may hold the port for up to MAX_HOLD
// consecutive grants via req_lock. Read data returns one cycle after the
// read grant, tagged to the issuing requester through req_rvalid.
module generic_sram_line_en_arbiter #(
  parameter int N_REQ         = 2,
  parameter int MEM_ADDR_BITS = 10,
  parameter int MEM_DATA_BITS = 1024,
  parameter int MAX_HOLD      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req_read_en,
  input  logic [N_REQ-1:0]                 req_write_en,
  input  logic [N_REQ-1:0]                 req_lock,
  input  logic [N_REQ*MEM_ADDR_BITS-1:0]   req_addr,
  input  logic [N_REQ*MEM_DATA_BITS-1:0]   req_write_data,
  output logic [N_REQ-1:0]                 req_gnt,
  output logic [N_REQ-1:0]                 req_rvalid,
  output logic [MEM_DATA_BITS-1:0]         req_read_data,
  output logic [MEM_ADDR_BITS-1:0]         sram_addr,
  output logic                             sram_read_en,
  output logic                             sram_write_en,
  output logic [MEM_DATA_BITS-1:0]         sram_write_data,
  input  logic [MEM_DATA_BITS-1:0]         sram_read_data
);

  localparam int PW = $clog2(N_REQ);
  // Wide enough to hold MAX_HOLD-1 even when MAX_HOLD is a power of two.
  localparam int CW = $clog2(MAX_HOLD) + 1;

  logic [N_REQ-1:0] active;

  // Arbitration state
  logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0] owner_reg, owner_next;
  logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          locked_reg, locked_next;

  // Current-cycle grant decision
  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand_idx;
  logic [CW-1:0] cur_cnt;

  // One-deep read return pipeline
  logic          rvalid_reg;
  logic [PW-1:0] ridx_reg;

  assign active = req_read_en | req_write_en;

  // Pick the winner: a locked, still-active owner first, else round-robin from rr_ptr.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    if (locked_reg && active[owner_reg]) begin
      gnt_any = 1'b1;
      gnt_idx = owner_reg;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cand_idx = PW'((int'(rr_ptr_reg) + i) % N_REQ);
        if (!gnt_any && active[cand_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = cand_idx;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_gnt[gi]    = gnt_any && (gnt_idx == PW'(gi));
      assign req_rvalid[gi] = rvalid_reg && (ridx_reg == PW'(gi));
    end
  endgenerate

  // With no grant gnt_idx is 0, so the mux idles on slice 0.
  assign sram_addr       = req_addr[int'(gnt_idx)*MEM_ADDR_BITS +: MEM_ADDR_BITS];
  assign sram_write_data = req_write_data[int'(gnt_idx)*MEM_DATA_BITS +: MEM_DATA_BITS];
  // Write wins when a requester raises both enables.
  assign sram_write_en   = gnt_any && req_write_en[gnt_idx];
  assign sram_read_en    = gnt_any && req_read_en[gnt_idx] && !req_write_en[gnt_idx];
  assign req_read_data   = sram_read_data;

  // Next arbitration state: advance the pointer past the winner and track the lock run.
  always_comb begin
    rr_ptr_next   = rr_ptr_reg;
    owner_next    = owner_reg;
    hold_cnt_next = hold_cnt_reg;
    locked_next   = locked_reg;
    // A grant to anyone other than the current locked owner starts a fresh run.
    cur_cnt       = (locked_reg && (owner_reg == gnt_idx)) ? hold_cnt_reg : '0;
    if (gnt_any) begin
      rr_ptr_next = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      if (req_lock[gnt_idx] && (cur_cnt < CW'(MAX_HOLD-1))) begin
        locked_next   = 1'b1;
        owner_next    = gnt_idx;
        hold_cnt_next = cur_cnt + 1'b1;
      end else begin
        locked_next   = 1'b0;
        hold_cnt_next = '0;
      end
    end else if (locked_reg) begin
      // Owner went idle: drop the lock; rr_ptr already points past it.
      locked_next   = 1'b0;
      hold_cnt_next = '0;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      hold_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
      locked_reg   <= locked_next;
    end
  end

  // Remember which requester issued this cycle's read so its data can be tagged next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_reg <= 1'b0;
      ridx_reg   <= '0;
    end else begin
      rvalid_reg <= sram_read_en;
      ridx_reg   <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_generic_sram_line_en_arbiter.sv
// Self-checking bench for generic_sram_line_en_arbiter (N_REQ=2, MAX_HOLD=4).
// A behavioural SRAM sits on the memory side; read returns are matched
// against a scoreboard filled when each read grant is expected.
module tb_generic_sram_line_en_arbiter;
  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int MH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_read_en, req_write_en, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_write_data;
  logic [N-1:0]    req_gnt, req_rvalid;
  logic [DW-1:0]   req_read_data;
  logic [AW-1:0]   sram_addr;
  logic            sram_read_en, sram_write_en;
  logic [DW-1:0]   sram_write_data, sram_read_data;

  generic_sram_line_en_arbiter #(
    .N_REQ(N), .MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read_en(req_read_en), .req_write_en(req_write_en), .req_lock(req_lock),
    .req_addr(req_addr), .req_write_data(req_write_data),
    .req_gnt(req_gnt), .req_rvalid(req_rvalid), .req_read_data(req_read_data),
    .sram_addr(sram_addr), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM, one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_write_en) mem[sram_addr] <= sram_write_data;
    if (sram_read_en)  sram_read_data <= mem[sram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    int          due;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  logic [DW-1:0] shadow [int];

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Read-return monitor: every rvalid must match the oldest expected read, on time.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      total++;
      if (req_rvalid !== oh(mon_e.idx) || req_read_data !== mon_e.data) begin
        $display("FAIL rdata_return cyc=%0d: rvalid=%b data=%h, required rvalid=%b data=%h",
                 cyc, req_rvalid, req_read_data, oh(mon_e.idx), mon_e.data);
      end else begin
        passed++;
        $display("read return cyc=%0d req=%0d data=%h", cyc, mon_e.idx, req_read_data);
      end
    end else if (req_rvalid !== '0) begin
      total++;
      $display("FAIL unexpected_rvalid cyc=%0d: rvalid=%b, required 00", cyc, req_rvalid);
    end
  end

  task automatic clear_req();
    req_read_en = '0; req_write_en = '0; req_lock = '0;
    req_addr = '0; req_write_data = '0;
  endtask

  task automatic set_req(input int r, input logic rd, input logic wr, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read_en[r]  = rd;
    req_write_en[r] = wr;
    req_lock[r]     = lk;
    req_addr[r*AW +: AW]       = a;
    req_write_data[r*DW +: DW] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      clear_req();
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_req();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Single write or read by requester r, alone on the bus, expecting an immediate grant.
  task automatic solo_access(input string name, input int r, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    clear_req();
    set_req(r, !wr, wr, 1'b0, a, d);
    @(negedge clk);
    total++;
    if (req_gnt !== oh(r) || sram_write_en !== wr || sram_read_en !== !wr || sram_addr !== a) begin
      $display("FAIL %s: gnt=%b we=%b re=%b addr=%h, required gnt=%b we=%b re=%b addr=%h",
               name, req_gnt, sram_write_en, sram_read_en, sram_addr, oh(r), wr, !wr, a);
    end else begin
      passed++;
      $display("%s cyc=%0d req=%0d %s addr=%h", name, cyc, r, wr ? "write" : "read", a);
    end
    if (wr) begin
      total++;
      if (sram_write_data !== d) begin
        $display("FAIL %s_wdata: data=%h, required %h", name, sram_write_data, d);
      end else begin
        passed++;
      end
      shadow[int'(a)] = d;
    end else begin
      sb.push_back('{idx: r, data: shadow[int'(a)], due: cyc + 1});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_req();
    @(negedge clk);
    total++;
    if (req_gnt !== '0 || req_rvalid !== '0 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0) begin
      $display("FAIL reset_state: gnt=%b rvalid=%b re=%b we=%b, required all 0",
               req_gnt, req_rvalid, sram_read_en, sram_write_en);
    end else begin
      passed++;
      $display("reset state ok");
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_gnt !== '0 || req_rvalid !== '0) begin
      $display("FAIL post_reset_idle: gnt=%b rvalid=%b, required 00 00", req_gnt, req_rvalid);
    end else begin
      passed++;
      $display("post-reset idle ok");
    end
  endtask

  task automatic test_single();
    solo_access("single_write", 0, 1'b1, 10'h005, 64'hA5A5_0000_1234_5678);
    solo_access("single_read", 0, 1'b0, 10'h005, '0);
    idle(2);
  endtask

  task automatic test_contention();
    logic [AW-1:0] addr_of [N];
    addr_of[0] = 10'h020;
    addr_of[1] = 10'h021;
    solo_access("preload0", 0, 1'b1, addr_of[0], 64'h0123_4567_89AB_CDEF);
    solo_access("preload1", 0, 1'b1, addr_of[1], 64'hFEDC_BA98_7654_3210);
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      clear_req();
      set_req(0, 1'b1, 1'b0, 1'b0, addr_of[0], '0);
      set_req(1, 1'b1, 1'b0, 1'b0, addr_of[1], '0);
      @(negedge clk);
      total++;
      if (req_gnt !== oh(c % 2) || sram_read_en !== 1'b1 || sram_addr !== addr_of[c % 2]) begin
        $display("FAIL contention_%0d: gnt=%b re=%b addr=%h, required gnt=%b re=1 addr=%h",
                 c, req_gnt, sram_read_en, sram_addr, oh(c % 2), addr_of[c % 2]);
      end else begin
        passed++;
        $display("contention cyc=%0d grant req=%0d", cyc, c % 2);
      end
      sb.push_back('{idx: c % 2, data: shadow[int'(addr_of[c % 2])], due: cyc + 1});
    end
    idle(2);
  endtask

  task automatic test_lock();
    logic [N-1:0] exp_gnt [6];
    logic         r0_done;
    exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    r0_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      clear_req();
      set_req(1, 1'b0, 1'b1, 1'b1, 10'h030, 64'h1111_2222_3333_4444);
      if (c >= 1 && !r0_done) set_req(0, 1'b1, 1'b0, 1'b0, 10'h020, '0);
      @(negedge clk);
      total++;
      if (req_gnt !== exp_gnt[c]) begin
        $display("FAIL lock_%0d: gnt=%b, required %b", c, req_gnt, exp_gnt[c]);
      end else begin
        passed++;
        $display("lock cyc=%0d grant=%b", cyc, req_gnt);
      end
      if (exp_gnt[c] == 2'b01) begin
        r0_done = 1'b1;
        sb.push_back('{idx: 0, data: shadow[32'h020], due: cyc + 1});
      end else begin
        shadow[32'h030] = 64'h1111_2222_3333_4444;
      end
    end
    idle(2);
    solo_access("lock_readback", 0, 1'b0, 10'h030, '0);
    idle(2);
  endtask

  task automatic test_read_write_both();
    @(posedge clk); #1;
    clear_req();
    set_req(0, 1'b1, 1'b1, 1'b0, 10'h010, 64'hBEEF_CAFE_0000_0010);
    @(negedge clk);
    total++;
    if (req_gnt !== 2'b01 || sram_write_en !== 1'b1 || sram_read_en !== 1'b0 || sram_addr !== 10'h010) begin
      $display("FAIL rw_both: gnt=%b we=%b re=%b addr=%h, required gnt=01 we=1 re=0 addr=010",
               req_gnt, sram_write_en, sram_read_en, sram_addr);
    end else begin
      passed++;
      $display("rw_both cyc=%0d write wins", cyc);
    end
    shadow[32'h010] = 64'hBEEF_CAFE_0000_0010;
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    total++;
    if (req_rvalid !== '0) begin
      $display("FAIL rw_both_no_rvalid: rvalid=%b, required 00", req_rvalid);
    end else begin
      passed++;
      $display("rw_both cyc=%0d no rvalid", cyc);
    end
    solo_access("rw_readback", 0, 1'b0, 10'h010, '0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    solo_access("b2b_0", 1, 1'b0, 10'h010, '0);
    solo_access("b2b_1", 1, 1'b0, 10'h005, '0);
    solo_access("b2b_2", 1, 1'b0, 10'h030, '0);
    solo_access("b2b_3", 0, 1'b0, 10'h021, '0);
    idle(2);
  endtask

  task automatic test_reset_mid();
    // Grant to 0 leaves rr_ptr at 1, so only a real reset sends the next contended grant to 0.
    @(posedge clk); #1;
    clear_req();
    set_req(0, 1'b1, 1'b0, 1'b0, 10'h005, '0);
    @(negedge clk);
    total++;
    if (req_gnt !== 2'b01 || sram_read_en !== 1'b1) begin
      $display("FAIL reset_mid_read: gnt=%b re=%b, required gnt=01 re=1", req_gnt, sram_read_en);
    end else begin
      passed++;
      $display("reset_mid read granted cyc=%0d", cyc);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_req();
    @(negedge clk);
    total++;
    if (req_rvalid !== '0 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0 || req_gnt !== '0) begin
      $display("FAIL reset_mid_flush: rvalid=%b re=%b we=%b gnt=%b, required all 0",
               req_rvalid, sram_read_en, sram_write_en, req_gnt);
    end else begin
      passed++;
      $display("reset_mid flushed cyc=%0d", cyc);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_rvalid !== '0) begin
      $display("FAIL reset_mid_release: rvalid=%b, required 00", req_rvalid);
    end else begin
      passed++;
      $display("reset_mid release quiet cyc=%0d", cyc);
    end
    @(posedge clk); #1;
    clear_req();
    set_req(0, 1'b1, 1'b0, 1'b0, 10'h005, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 10'h010, '0);
    @(negedge clk);
    total++;
    if (req_gnt !== 2'b01) begin
      $display("FAIL reset_mid_rrptr: gnt=%b, required 01", req_gnt);
    end else begin
      passed++;
      $display("reset_mid contended grant req=0 cyc=%0d", cyc);
    end
    sb.push_back('{idx: 0, data: shadow[32'h005], due: cyc + 1});
    idle(3);
  endtask

  initial begin
    clear_req();
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_read_write_both();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() !== 0) begin
      $display("FAIL scoreboard_drain: pending=%0d, required 0", sb.size());
    end else begin
      passed++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
